// File: rtl/rsa_montgomery_multi_pkg.sv
// Shared types and helpers for the iterative Montgomery multiplier.
package rsa_montgomery_multi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } MontState_t;

    function automatic int mont_rounds(input int width, input int bpr);
        return width / bpr;
    endfunction

endpackage

// File: rtl/rsa_montgomery_multi_step.sv
// One combinational radix-2 Montgomery iteration: add b if a_bit is set,
// make the sum even by adding N, then halve it.
module rsa_montgomery_step #(
    parameter int MOD_WIDTH = 256
) (
    input  logic [MOD_WIDTH+1:0] acc,
    input  logic [MOD_WIDTH+1:0] b,
    input  logic [MOD_WIDTH+1:0] n,
    input  logic                 a_bit,
    output logic [MOD_WIDTH+1:0] acc_next
);

    logic [MOD_WIDTH+1:0] sum;
    logic [MOD_WIDTH+1:0] even_sum;

    // With acc < 2N and b < N the sum stays below 4N, so two guard bits suffice.
    always_comb begin
        sum      = acc + (a_bit ? b : '0);
        even_sum = sum[0] ? sum + n : sum;
        acc_next = even_sum >> 1;
    end

endmodule

// File: rtl/rsa_montgomery_multi.sv
// Iterative Montgomery multiplier, out = a * b * 2^-MOD_WIDTH mod N, consuming
// BITS_PER_ROUND multiplier bits per cycle followed by one final-reduction cycle.
module rsa_montgomery_multi
    import rsa_montgomery_multi_pkg::*;
#(
    parameter int MOD_WIDTH      = 256,
    parameter int BITS_PER_ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [MOD_WIDTH-1:0] i_a,
    input  logic [MOD_WIDTH-1:0] i_b,
    input  logic [MOD_WIDTH-1:0] i_modulus,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [MOD_WIDTH-1:0] o_out
);

    localparam int ROUNDS = mont_rounds(MOD_WIDTH, BITS_PER_ROUND);
    localparam int CW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int AW     = MOD_WIDTH + 2;

    if (!(BITS_PER_ROUND == 1 || BITS_PER_ROUND == 2 || BITS_PER_ROUND == 4 ||
          BITS_PER_ROUND == 8) || (MOD_WIDTH % BITS_PER_ROUND) != 0) begin : g_bad_param
        $fatal(1, "rsa_montgomery_multi: BITS_PER_ROUND must be 1/2/4/8 and divide MOD_WIDTH");
    end

    MontState_t           state, state_next;
    logic [CW-1:0]        counter, counter_next;
    logic [MOD_WIDTH-1:0] a_reg, a_next;
    logic [AW-1:0]        b_reg, b_next;
    logic [AW-1:0]        n_reg, n_next;
    logic [AW-1:0]        acc, acc_next;
    logic [MOD_WIDTH-1:0] out_reg, out_next;
    logic [AW-1:0]        round_acc;

    // The multiplier is shifted down each round, so step j always sees a_reg[j].
    for (genvar j = 0; j < BITS_PER_ROUND; j++) begin : g_step
        logic [AW-1:0] acc_in;
        logic [AW-1:0] acc_out;
        if (j == 0) begin : g_first
            assign acc_in = acc;
        end else begin : g_rest
            assign acc_in = g_step[j-1].acc_out;
        end
        rsa_montgomery_step #(.MOD_WIDTH(MOD_WIDTH)) u_step (
            .acc      (acc_in),
            .b        (b_reg),
            .n        (n_reg),
            .a_bit    (a_reg[j]),
            .acc_next (acc_out)
        );
    end

    assign round_acc = g_step[BITS_PER_ROUND-1].acc_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            counter <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            n_reg   <= '0;
            acc     <= '0;
            out_reg <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            a_reg   <= a_next;
            b_reg   <= b_next;
            n_reg   <= n_next;
            acc     <= acc_next;
            out_reg <= out_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        a_next       = a_reg;
        b_next       = b_reg;
        n_next       = n_reg;
        acc_next     = acc;
        out_next     = out_reg;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    a_next       = i_a;
                    b_next       = {2'b00, i_b};
                    n_next       = {2'b00, i_modulus};
                    acc_next     = '0;
                    counter_next = '0;
                    state_next   = CALC;
                end
            end
            CALC: begin
                acc_next = round_acc;
                a_next   = a_reg >> BITS_PER_ROUND;
                if (counter == CW'(ROUNDS - 1)) begin
                    counter_next = '0;
                    state_next   = REDUCE;
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
            // acc equal to N must reduce to zero, hence >= rather than >.
            REDUCE: begin
                out_next   = MOD_WIDTH'((acc >= n_reg) ? acc - n_reg : acc);
                state_next = DONE;
            end
            DONE: begin
                if (o_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign i_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_out   = out_reg;

endmodule

// File: tb/tb_rsa_montgomery_multi.sv
// Directed bench for rsa_montgomery_multi: 8-bit units at 1/2/4 bits per round
// and 256-bit units at 1/2/4/8 bits per round, all checked with immediate asserts.
module tb_rsa_montgomery_multi;

    logic clk;
    logic rst;

    logic       iv8, or8;
    logic [7:0] a8, b8, n8;
    logic       ir8 [3];
    logic       ov8 [3];
    logic [7:0] out8 [3];

    logic         iv256, or256;
    logic [255:0] a256, b256, n256;
    logic         ir256 [4];
    logic         ov256 [4];
    logic [255:0] out256 [4];

    int checks = 0;
    int errors = 0;

    for (genvar k = 0; k < 3; k++) begin : g_u8
        rsa_montgomery_multi #(.MOD_WIDTH(8), .BITS_PER_ROUND(1 << k)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_valid   (iv8),
            .i_ready   (ir8[k]),
            .i_a       (a8),
            .i_b       (b8),
            .i_modulus (n8),
            .o_valid   (ov8[k]),
            .o_ready   (or8),
            .o_out     (out8[k])
        );
    end

    for (genvar k = 0; k < 4; k++) begin : g_u256
        rsa_montgomery_multi #(.MOD_WIDTH(256), .BITS_PER_ROUND(1 << k)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_valid   (iv256),
            .i_ready   (ir256[k]),
            .i_a       (a256),
            .i_b       (b256),
            .i_modulus (n256),
            .o_valid   (ov256[k]),
            .o_ready   (or256),
            .o_out     (out256[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [255:0] observed,
                                input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Runs one 8-bit operation on all three units; optionally holds the result
    // under back-pressure while pulsing i_valid before retiring it.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] n, input logic [7:0] expected,
                                  input bit hold, input string tag);
        int lat [3];
        int cyc;
        @(negedge clk);
        a8 = a; b8 = b; n8 = n; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = '{default: 0};
        cyc = 0;
        while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            for (int k = 0; k < 3; k++) if (ov8[k] && lat[k] == 0) lat[k] = cyc;
        end
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("%s latency bpr%0d", tag, 1 << k), 256'(lat[k]),
                         256'((8 >> k) + 1));
            check_output($sformatf("%s out bpr%0d", tag, 1 << k), 256'(out8[k]),
                         256'(expected));
        end
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                iv8 = c[0];
                a8 = 8'd2; b8 = 8'd3;
                @(posedge clk); #1;
                check_output($sformatf("%s hold valid %0d", tag, c), 256'(ov8[0]), 256'(1));
                check_output($sformatf("%s hold out %0d", tag, c), 256'(out8[0]), 256'(expected));
                check_output($sformatf("%s hold ready %0d", tag, c), 256'(ir8[0]), 256'(0));
            end
            iv8 = 1'b0;
        end
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("%s ready after retire bpr%0d", tag, 1 << k),
                         256'(ir8[k]), 256'(1));
            check_output($sformatf("%s valid after retire bpr%0d", tag, 1 << k),
                         256'(ov8[k]), 256'(0));
        end
        if (hold) check_output({tag, " out kept"}, 256'(out8[0]), 256'(expected));
    endtask

    // Runs one 256-bit operation on all four units and checks the result through
    // the defining congruence out * 2^256 == a * b (mod N) with out < N.
    task automatic apply_wide(input logic [255:0] a, input logic [255:0] b,
                              input logic [255:0] n, input bit expect_zero,
                              input string tag);
        int lat [4];
        int cyc;
        logic [511:0] ref_mod;
        logic [511:0] obs_mod;
        @(negedge clk);
        a256 = a; b256 = b; n256 = n; iv256 = 1'b1;
        @(posedge clk); #1;
        iv256 = 1'b0;
        lat = '{default: 0};
        cyc = 0;
        while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0 || lat[3] == 0) && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            for (int k = 0; k < 4; k++) if (ov256[k] && lat[k] == 0) lat[k] = cyc;
        end
        ref_mod = ({256'd0, a} * {256'd0, b}) % {256'd0, n};
        for (int k = 0; k < 4; k++) begin
            obs_mod = {out256[k], 256'd0} % {256'd0, n};
            check_output($sformatf("%s latency bpr%0d", tag, 1 << k), 256'(lat[k]),
                         256'((256 >> k) + 1));
            check_output($sformatf("%s congruence bpr%0d", tag, 1 << k), obs_mod[255:0],
                         ref_mod[255:0]);
            check_output($sformatf("%s below N bpr%0d", tag, 1 << k),
                         256'(out256[k] < n), 256'(1));
            if (expect_zero)
                check_output($sformatf("%s zero bpr%0d", tag, 1 << k), out256[k], 256'd0);
        end
        @(negedge clk);
        or256 = 1'b1;
        @(posedge clk); #1;
        or256 = 1'b0;
    endtask

    initial begin
        logic [255:0] n_r, a_r, b_r;
        logic [127:0] p, q;
        bit seen_valid;

        rst = 1'b0;
        iv8 = 1'b1; or8 = 1'b0; a8 = 8'd5; b8 = 8'd7; n8 = 8'd13;
        iv256 = 1'b1; or256 = 1'b0; a256 = '0; b256 = '0; n256 = 256'd13;

        // Reset with i_valid high: nothing may start.
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("reset valid bpr%0d", 1 << k), 256'(ov8[k]), 256'(0));
            check_output($sformatf("reset out bpr%0d", 1 << k), 256'(out8[k]), 256'(0));
        end
        iv8 = 1'b0; iv256 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++)
            check_output($sformatf("post-reset ready bpr%0d", 1 << k), 256'(ir8[k]), 256'(1));
        check_output("post-reset ready wide", 256'(ir256[0]), 256'(1));

        $display("[TB] 8-bit directed vectors");
        apply_stimulus(8'd5,  8'd7,  8'd13, 8'd1, 1'b0, "n13 a5 b7");
        apply_stimulus(8'd0,  8'd7,  8'd13, 8'd0, 1'b0, "n13 a0 b7");
        apply_stimulus(8'd1,  8'd1,  8'd13, 8'd3, 1'b0, "n13 a1 b1");
        apply_stimulus(8'd12, 8'd12, 8'd13, 8'd3, 1'b0, "n13 a12 b12");
        apply_stimulus(8'd3,  8'd5,  8'd15, 8'd0, 1'b0, "n15 acc==N");
        apply_stimulus(8'd5,  8'd7,  8'd13, 8'd1, 1'b1, "backpressure");

        $display("[TB] reset during CALC");
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; n8 = 8'd13; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("abort ready bpr%0d", 1 << k), 256'(ir8[k]), 256'(1));
            check_output($sformatf("abort out bpr%0d", 1 << k), 256'(out8[k]), 256'(0));
        end
        seen_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ov8[0] || ov8[1] || ov8[2]) seen_valid = 1'b1;
        end
        check_output("abort no valid", 256'(seen_valid), 256'(0));
        apply_stimulus(8'd12, 8'd12, 8'd13, 8'd3, 1'b0, "after abort");

        $display("[TB] 256-bit vectors");
        for (int v = 0; v < 12; v++) begin
            n_r = rand256();
            n_r[255] = 1'b1;
            n_r[0] = 1'b1;
            a_r = rand256() % n_r;
            b_r = rand256() % n_r;
            if (v == 0) a_r = 256'd1;
            if (v == 1) b_r = n_r - 256'd1;
            apply_wide(a_r, b_r, n_r, 1'b0, $sformatf("wide%0d", v));
        end
        p = {$urandom, $urandom, $urandom, $urandom};
        q = {$urandom, $urandom, $urandom, $urandom};
        p[127] = 1'b1; p[0] = 1'b1;
        q[127] = 1'b1; q[0] = 1'b1;
        n_r = {128'd0, p} * {128'd0, q};
        apply_wide({128'd0, p}, {128'd0, q}, n_r, 1'b1, "wide pq");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
